// File: rtl/mb_wdata_packer.sv
// mb_wdata_packer: packs 128-bit encoder words into 1024-bit beats, one
// macroblock = 7 beats, and queues beats in a first-word-fall-through FIFO
// feeding the AXI write-data stage (fifo_empty / fifo_dout / fifo_rd).

// One word lane of the beat assembler: holds word k of the beat in flight.
module mb_wdata_lane #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Capture the encoder word when this lane is the current write slot.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module mb_wdata_packer #(
    parameter int IN_W         = 128,
    parameter int BEATS_PER_MB = 7,
    parameter int DEPTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pulse,
    input  logic [31:0]          mb_w,
    input  logic [31:0]          mb_h,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in_data,
    output logic                 in_ready,
    output logic                 fifo_empty,
    output logic [1023:0]        fifo_dout,
    input  logic                 fifo_rd,
    output logic                 done_pulse,
    output logic                 rd_underflow
);
    localparam int BEAT_W = 1024;
    localparam int WPB    = BEAT_W / IN_W;
    localparam int WC_W   = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BC_W   = (BEATS_PER_MB > 1) ? $clog2(BEATS_PER_MB) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DRAIN, S_DONE} state_t;

    // Beat write request into the FIFO.
    typedef struct packed {
        logic              wr;
        logic [BEAT_W-1:0] data;
    } beat_req_t;

    state_t              state;
    logic [21:0]         mb_total;
    logic [21:0]         mb_cnt;
    logic [21:0]         mb_prod;
    logic [WC_W-1:0]     word_cnt;
    logic [BC_W-1:0]     beat_cnt;

    logic [BEAT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       fifo_count;
    logic                full;
    logic                fifo_pop;

    logic                accept;
    logic                beat_done;
    logic                mb_done;
    logic                last_word;
    beat_req_t           beat_req;

    logic [WPB-2:0][IN_W-1:0] lane_q;

    // Only the low 11 bits of the frame dimensions are meaningful.
    logic                unused_dims;
    assign unused_dims = ^{mb_w[31:11], mb_h[31:11]};

    assign mb_prod    = 22'(mb_w[10:0]) * 22'(mb_h[10:0]);
    assign full       = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = fifo_rd && !fifo_empty;

    // in_ready comes from registered state only; a same-cycle pop never
    // opens a full FIFO for a write.
    assign in_ready   = (state == S_PACK) && !full;
    assign done_pulse = (state == S_DONE);

    assign accept     = in_valid && in_ready;
    assign beat_done  = accept && (word_cnt == WC_W'(WPB - 1));
    assign mb_done    = beat_done && (beat_cnt == BC_W'(BEATS_PER_MB - 1));
    assign last_word  = mb_done && ((mb_cnt + 22'd1) == mb_total);

    // The final word goes straight into the beat, so it costs no extra cycle.
    assign beat_req.wr   = beat_done;
    assign beat_req.data = {in_data, lane_q};

    // Word lanes 0..WPB-2; word 0 lands in the LSBs of the beat.
    genvar k;
    generate
        for (k = 0; k < WPB - 1; k++) begin : g_lane
            mb_wdata_lane #(.W(IN_W)) u_lane (
                .clk (clk),
                .rst (rst),
                .we  (accept && (word_cnt == WC_W'(k))),
                .d   (in_data),
                .q   (lane_q[k])
            );
        end
    endgenerate

    // Frame sequencing: word/beat/macroblock counting and state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mb_total <= '0;
            mb_cnt   <= '0;
            word_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        mb_total <= mb_prod;
                        mb_cnt   <= '0;
                        word_cnt <= '0;
                        beat_cnt <= '0;
                        state    <= (mb_prod == '0) ? S_DONE : S_PACK;
                    end
                end
                S_PACK: begin
                    if (accept) begin
                        word_cnt <= beat_done ? '0 : word_cnt + 1'b1;
                        if (beat_done) begin
                            beat_cnt <= mb_done ? '0 : beat_cnt + 1'b1;
                            if (mb_done) mb_cnt <= mb_cnt + 22'd1;
                            if (last_word) state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Beat storage is not reset; fifo_dout is masked while empty instead.
    always_ff @(posedge clk) begin
        if (beat_req.wr) mem[wr_ptr] <= beat_req.data;
    end

    // FIFO pointers and occupancy; reset drops all queued beats at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (beat_req.wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({beat_req.wr, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky underflow flag; an honoured start rearms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_underflow <= 1'b0;
        end else if (state == S_IDLE && start_pulse) begin
            rd_underflow <= fifo_rd && fifo_empty;
        end else if (fifo_rd && fifo_empty) begin
            rd_underflow <= 1'b1;
        end
    end

    assign fifo_dout = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_mb_wdata_packer.sv
// Self-checking bench for mb_wdata_packer: a scoreboard queue of expected
// beats is built as words are accepted and compared as beats are popped.
module tb_mb_wdata_packer;
    logic          clk = 1'b0;
    logic          rst;
    logic          start_pulse;
    logic [31:0]   mb_w, mb_h;
    logic          in_valid;
    logic [127:0]  in_data;
    logic          in_ready;
    logic          fifo_empty;
    logic [1023:0] fifo_dout;
    logic          fifo_rd;
    logic          done_pulse;
    logic          rd_underflow;

    mb_wdata_packer #(.IN_W(128), .BEATS_PER_MB(7), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .mb_w(mb_w), .mb_h(mb_h),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
        .done_pulse(done_pulse), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mw;
        int mh;
        int salt;
        int mode;   // 0: no pops while feeding, 1: pop whenever non-empty, 2: random pops
        int beats;  // expected beats delivered
    } vec_t;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [1023:0] exp_q[$];
    logic [1023:0] build;
    int            bw, widx, words_left, pop_mode, popped, done_seen, max_occ;
    bit            force_rd;
    logic [31:0]   salt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_beat(string name, logic [1023:0] act, logic [1023:0] exp);
        int lane;
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            lane = 0;
            for (int j = 7; j >= 0; j--)
                if (act[j*128 +: 128] !== exp[j*128 +: 128]) lane = j;
            $display("FAIL %s: lane %0d got %h expected %h", name, lane,
                     act[lane*128 +: 128], exp[lane*128 +: 128]);
        end
    endtask

    function automatic logic [127:0] mkword(int i);
        return {salt, 64'h0, 32'(i)};
    endfunction

    // One cycle: entered and left at a negedge; samples, drives, advances.
    task automatic tick();
        bit do_pop;
        if (done_pulse) done_seen++;
        if (exp_q.size() > max_occ) max_occ = exp_q.size();
        chk("empty_vs_model", 64'(fifo_empty), 64'(exp_q.size() == 0));
        case (pop_mode)
            1:       do_pop = !fifo_empty;
            2:       do_pop = !fifo_empty && ($urandom_range(0, 1) == 1);
            default: do_pop = 1'b0;
        endcase
        if (do_pop && exp_q.size() > 0) begin
            chk_beat("beat_data", fifo_dout, exp_q[0]);
            void'(exp_q.pop_front());
            popped++;
        end
        fifo_rd = do_pop || force_rd;
        if (words_left > 0) begin
            in_valid = 1'b1;
            in_data  = mkword(widx);
            if (in_ready) begin
                build[bw*128 +: 128] = in_data;
                bw++;
                widx++;
                words_left--;
                if (bw == 8) begin
                    exp_q.push_back(build);
                    bw = 0;
                end
            end
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(int mw, int mh);
        mb_w = 32'(mw);
        mb_h = 32'(mh);
        start_pulse = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_pulse = 1'b0;
        done_seen = 0;
        popped = 0;
        max_occ = 0;
        widx = 0;
        bw = 0;
    endtask

    // Feed remaining words, then pop everything and wait for done.
    task automatic finish_frame(int budget);
        int cyc;
        cyc = 0;
        while (!(words_left == 0 && done_seen > 0) && cyc < budget) begin
            if (words_left == 0 && pop_mode == 0) pop_mode = 1;
            tick();
            cyc++;
        end
        if (cyc >= budget) chk("frame_timeout", 64'(cyc), 64'(0));
        tick();
        tick();
    endtask

    task automatic run_frame(vec_t v);
        salt = 32'(v.salt);
        pop_mode = v.mode;
        start(v.mw, v.mh);
        words_left = v.mw * v.mh * 56;
        finish_frame(5000);
        chk("vec_done_once", 64'(done_seen), 64'(1));
        chk("vec_beats", 64'(popped), 64'(v.beats));
        chk("vec_model_empty", 64'(exp_q.size()), 64'(0));
        chk("vec_underflow", 64'(rd_underflow), 64'(0));
        if (v.mode == 1) chk("vec_max_occ_le1", 64'(max_occ <= 1), 64'(1));
    endtask

    vec_t vecs[4];

    initial begin
        int cyc;
        vecs[0] = '{mw: 2, mh: 2, salt: 11, mode: 1, beats: 28};
        vecs[1] = '{mw: 1, mh: 2, salt: 12, mode: 2, beats: 14};
        vecs[2] = '{mw: 3, mh: 1, salt: 13, mode: 2, beats: 21};
        vecs[3] = '{mw: 1, mh: 1, salt: 14, mode: 1, beats: 7};

        rst = 1'b1; start_pulse = 1'b0; mb_w = '0; mb_h = '0;
        in_valid = 1'b0; in_data = '0; fifo_rd = 1'b0; force_rd = 1'b0;
        bw = 0; widx = 0; words_left = 0; pop_mode = 0; popped = 0;
        done_seen = 0; max_occ = 0; salt = '0; build = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_fifo_empty", 64'(fifo_empty), 64'(1));
        chk("rst_done", 64'(done_pulse), 64'(0));
        chk("rst_underflow", 64'(rd_underflow), 64'(0));
        chk("rst_dout_zero", 64'(fifo_dout != '0), 64'(0));

        // Single macroblock, no reads while feeding
        salt = '0; pop_mode = 0;
        start(1, 1);
        chk("t1_ready_after_start", 64'(in_ready), 64'(1));
        words_left = 56;
        cyc = 0;
        while (words_left > 0 && cyc < 200) begin tick(); cyc++; end
        repeat (3) tick();
        chk("t1_not_empty", 64'(fifo_empty), 64'(0));
        chk("t1_ready_drain", 64'(in_ready), 64'(0));
        chk("t1_e0_lo", fifo_dout[63:0], 64'(0));
        chk("t1_e0_hi_lo64", fifo_dout[959:896], 64'(7));
        chk("t1_e0_hi_hi64", fifo_dout[1023:960], 64'(0));
        chk("t1_no_early_done", 64'(done_seen), 64'(0));
        pop_mode = 1;
        finish_frame(100);
        chk("t1_done_once", 64'(done_seen), 64'(1));
        chk("t1_beats", 64'(popped), 64'(7));
        chk("t1_empty_end", 64'(fifo_empty), 64'(1));

        // Table-driven frames (includes concurrent 2x2 streaming)
        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Backpressure: 3x1 frame fills the 16-deep FIFO
        salt = 32'd21; pop_mode = 0;
        start(3, 1);
        words_left = 168;
        cyc = 0;
        while (widx < 128 && cyc < 400) begin tick(); cyc++; end
        chk("t2_full_ready", 64'(in_ready), 64'(0));
        repeat (3) tick();
        chk("t2_stalled_words", 64'(widx), 64'(128));
        pop_mode = 1;
        tick();
        pop_mode = 0;
        chk("t2_ready_after_pop", 64'(in_ready), 64'(1));
        pop_mode = 2;
        finish_frame(5000);
        chk("t2_done_once", 64'(done_seen), 64'(1));
        chk("t2_beats", 64'(popped), 64'(21));
        chk("t2_words", 64'(widx), 64'(168));

        // Zero frame
        start(0, 5);
        chk("t4_done_n1", 64'(done_pulse), 64'(1));
        pop_mode = 0; words_left = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_ready", 64'(in_ready), 64'(0));
            tick();
        end
        chk("t4_done_once", 64'(done_seen), 64'(1));

        // Reset mid-frame
        salt = 32'd5; pop_mode = 0;
        start(1, 1);
        words_left = 20;
        cyc = 0;
        while (words_left > 0 && cyc < 100) begin tick(); cyc++; end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); bw = 0; words_left = 0; done_seen = 0;
        chk("t5_empty", 64'(fifo_empty), 64'(1));
        chk("t5_ready", 64'(in_ready), 64'(0));
        chk("t5_done", 64'(done_pulse), 64'(0));
        chk("t5_dout_zero", 64'(fifo_dout != '0), 64'(0));
        repeat (3) tick();
        chk("t5_no_done", 64'(done_seen), 64'(0));
        run_frame('{mw: 1, mh: 1, salt: 6, mode: 2, beats: 7});

        // Underflow sticky, ignored start in PACK, cleared on honoured start
        salt = 32'd7; pop_mode = 0;
        start(1, 1);
        words_left = 4;
        cyc = 0;
        while (words_left > 0 && cyc < 50) begin tick(); cyc++; end
        force_rd = 1'b1;
        tick();
        force_rd = 1'b0;
        chk("t6_underflow_set", 64'(rd_underflow), 64'(1));
        chk("t6_still_empty", 64'(fifo_empty), 64'(1));
        mb_w = 32'd0;
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        chk("t6_ign_start_ready", 64'(in_ready), 64'(1));
        chk("t6_ign_start_uf", 64'(rd_underflow), 64'(1));
        chk("t6_ign_start_done", 64'(done_pulse), 64'(0));
        words_left = 52; pop_mode = 2;
        finish_frame(2000);
        chk("t6_done_once", 64'(done_seen), 64'(1));
        chk("t6_beats", 64'(popped), 64'(7));
        chk("t6_uf_sticky", 64'(rd_underflow), 64'(1));
        salt = 32'd8; pop_mode = 1;
        start(1, 1);
        chk("t6_uf_cleared", 64'(rd_underflow), 64'(0));
        words_left = 56;
        finish_frame(2000);
        chk("t6_frame2_done", 64'(done_seen), 64'(1));
        chk("t6_frame2_beats", 64'(popped), 64'(7));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mb_wdata_packer.md
# mb_wdata_packer

Packs the WebPEncode per-macroblock output stream (128-bit words) into 1024-bit AXI beats and buffers them in an internal first-word-fall-through FIFO. It sits directly upstream of the AXI write-data channel stage and drives that stage's `fifo_empty` / `fifo_dout` / `fifo_rd` interface. Each macroblock is exactly 7 beats (56 input words). A frame is `mb_w[10:0] * mb_h[10:0]` macroblocks.

## Interface
Parameters:
- `IN_W`, 128: input word width; beat width is fixed at 1024, so `1024/IN_W` = 8 words per beat.
- `BEATS_PER_MB`, 7: beats per macroblock.
- `DEPTH`, 16: beat FIFO entries; must be a power of 2, ≥ 2.

Ports (clock and reset first):
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start_pulse`, input, 1: one-cycle frame start; honoured only in IDLE.
- `mb_w`, input, 32: macroblock columns; bits [10:0] are used.
- `mb_h`, input, 32: macroblock rows; bits [10:0] are used.
- `in_valid`, input, 1: encoder word valid.
- `in_data`, input, 128: encoder word.
- `in_ready`, output, 1: word accepted when `in_valid && in_ready`.
- `fifo_empty`, output, 1: no beat available.
- `fifo_dout`, output, 1024: head beat; valid whenever `!fifo_empty`.
- `fifo_rd`, input, 1: pop head beat this cycle.
- `done_pulse`, output, 1: one-cycle frame-complete pulse.
- `rd_underflow`, output, 1: sticky; `fifo_rd` was asserted while `fifo_empty`.

## Operation
FSM states are IDLE, PACK, DRAIN and DONE.
- **IDLE**
  - On `start_pulse`: latch `mb_total = mb_w[10:0]*mb_h[10:0]` (22 bits, unsigned) and clear `word_cnt`, `beat_cnt`, `mb_cnt` and `rd_underflow`.
  - Go to PACK, or straight to DONE if the product is 0.
- **PACK**
  - `in_ready = !full`.
  - Each accepted word is written into lane `word_cnt`: bits [128*k+127 : 128*k], so word 0 is in the LSBs.
  - On the 8th word (`word_cnt==7`) the assembled beat is written into the FIFO in the same cycle, `word_cnt` wraps to 0 and `beat_cnt` increments.
  - On `beat_cnt==6` wrap: `beat_cnt` goes to 0 and `mb_cnt` increments.
  - When the incremented `mb_cnt == mb_total`, go to DRAIN.
- **DRAIN**
  - `in_ready = 0`.
  - Stay until FIFO occupancy is 0, then go to DONE.
- **DONE**
  - `done_pulse = 1` for this single cycle.
  - Next state is IDLE.
- `start_pulse` outside IDLE is ignored.
- **FIFO**
  - Occupancy counter runs 0..DEPTH; `full = (count==DEPTH)`.
  - A write occurs only on the beat-completing accepted word.
  - A read occurs on `fifo_rd && !fifo_empty`.
  - Simultaneous read and write leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- `fifo_rd` while empty: no pop, no pointer change; set `rd_underflow`. It is cleared only by `rst` or an honoured `start_pulse`.
- Beats are popped in any state, including IDLE, so the downstream stage may lag.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready=0`, `fifo_empty=1`, `done_pulse=0`, `rd_underflow=0`.
  - `fifo_dout` = 0; the FIFO storage need not be reset, but `fifo_dout` is masked while empty.
  - All counters and pointers are 0.
- `rst` mid-operation discards partial beats and all FIFO contents on the same edge.
- `start_pulse` sampled at edge N puts the FSM in PACK in cycle N+1, where `in_ready` can first be 1.
- Beat-completing word accepted at edge N: `fifo_empty` is low and `fifo_dout` shows the beat in cycle N+1 (1-cycle latency, first-word-fall-through).
- `fifo_rd` at edge N: the next beat appears, or `fifo_empty` rises, in cycle N+1. `fifo_dout` is combinationally from the head entry, with no read latency.
- `in_ready` is registered-state based only: it depends on FSM state and `full`, never combinationally on `in_valid` or `fifo_rd`. A pop in the same cycle does not free a full FIFO for a write until the next cycle.
- Last word of the frame at edge N: DRAIN in cycle N+1.
  - If the FIFO is already empty at that point, DONE follows in cycle N+2.
  - Otherwise DONE is the cycle after the last pop.

## Test plan
1. **Single macroblock, no reads.** `mb_w=1, mb_h=1`, 56 words with `in_data = index`, `fifo_rd=0`. Require:
   - 7 entries; entry 0 has bits [127:0]=0 and [1023:896]=7; entry 6 has [1023:896]=55.
   - Then pulse `fifo_rd` 7 times: `fifo_empty=1`, then `done_pulse` high for exactly 1 cycle.
2. **Backpressure.** `DEPTH=16`, `mb_w=3, mb_h=1` (21 beats), `fifo_rd=0`. Require:
   - `in_ready` drops after 128 accepted words (count=16).
   - After one pop, `in_ready` returns 1 cycle later; all 168 words are delivered in order.
3. **Concurrent streaming.** `mb_w=2, mb_h=2`, `in_valid=1` every cycle, `fifo_rd = !fifo_empty` every cycle. Require:
   - 28 beats popped, bit-exact.
   - Occupancy never exceeds 1; `done_pulse` once; `rd_underflow=0`.
4. **Zero frame.** `mb_w=0, mb_h=5`, `start_pulse`. Require:
   - `in_ready` never 1.
   - `done_pulse` in cycle N+1 after the `start_pulse` edge N; return to IDLE.
5. **Reset mid-frame.** Accept 20 words of a 1×1 frame, assert `rst` for 1 cycle. Require:
   - `fifo_empty=1`, `in_ready=0`, no `done_pulse`.
   - A new `start_pulse` with a 1×1 frame of 56 words yields 7 correct beats.
6. **Underflow and ignored start.** `fifo_rd=1` while empty sets `rd_underflow` sticky with no pointer change. `start_pulse` during PACK changes nothing. The next honoured `start_pulse` clears `rd_underflow`.
